load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: formats byte/halfword/word accesses onto a word-wide
// request/acknowledge memory port, with alignment checks and an ack timeout.
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  output logic        MemWE,
  output logic [3:0]  MemBE,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic [31:0] ReadData,
  output logic        Done,
  output logic        Busy,
  output logic        Err
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic [2:0]      funct3_q;
  logic [3:0]      be_q;
  logic            we_q, err_q;
  logic [CntW-1:0] cnt_q;

  logic            accept, illegal, timeout;
  logic [3:0]      be_d;
  logic [31:0]     wdata_d, load_ext, shifted;

  assign accept  = (state_q == StIdle) && Start && (MemRead ^ MemWrite);
  assign timeout = (state_q == StReq) && !MemAck && (cnt_q == CntLast);

  // Alignment and encoding legality, evaluated on the raw inputs at Start.
  always_comb begin
    illegal = 1'b0;
    if (MemRead) begin
      case (Funct3)
        3'b000, 3'b100: illegal = 1'b0;
        3'b001, 3'b101: illegal = ALUResult[0];
        3'b010:         illegal = |ALUResult[1:0];
        default:        illegal = 1'b1;
      endcase
    end else begin
      case (Funct3)
        3'b000:  illegal = 1'b0;
        3'b001:  illegal = ALUResult[0];
        3'b010:  illegal = |ALUResult[1:0];
        default: illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteData;
    if (MemWrite) begin
      case (Funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << ALUResult[1:0];
          wdata_d = {4{WriteData[7:0]}};
        end
        2'b01: begin
          be_d    = ALUResult[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{WriteData[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = WriteData;
        end
      endcase
    end
  end

  // Selected lane lands in the low bits; halfwords are aligned so a 16-bit shift suffices.
  always_comb begin
    shifted = MemRData >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = MemRData;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = illegal ? StResp : StReq;
      end
      StReq: begin
        if (MemAck || timeout) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    MemReq   = (state_q == StReq);
    Busy     = (state_q != StIdle);
    Done     = (state_q == StResp);
    Err      = Done & err_q;
    MemWE    = MemReq & we_q;
    MemBE    = be_q;
    MemAddr  = {addr_q[31:2], 2'b00};
    MemWData = wdata_q;
    ReadData = rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        addr_q   <= ALUResult;
        funct3_q <= Funct3;
        we_q     <= MemWrite;
        be_q     <= be_d;
        wdata_q  <= wdata_d;
        err_q    <= illegal;
        cnt_q    <= '0;
      end else if (state_q == StReq && !MemAck) begin
        cnt_q <= cnt_q + CntW'(1);
        if (timeout) err_q <= 1'b1;
      end
      if (state_q == StReq && MemAck && !we_q) rdata_q <= load_ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table of accesses plus
// hand-written timeout, reset, busy-start and ignored-request sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Start, MemRead, MemWrite, MemAck;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData, MemRData;
  logic        MemReq, MemWE, Done, Busy, Err;
  logic [31:0] MemAddr, MemWData, ReadData;
  logic [3:0]  MemBE;

  load_store_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData), .MemReq(MemReq),
    .MemAddr(MemAddr), .MemWE(MemWE), .MemBE(MemBE), .MemWData(MemWData), .MemAck(MemAck),
    .MemRData(MemRData), .ReadData(ReadData), .Done(Done), .Busy(Busy), .Err(Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdat;
    logic        req;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic        err;
    logic [31:0] rres;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        tbl[16];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] model_rd = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic wait_done(input string tag, input int extra);
    int   i;
    exp_t e;
    i = 0;
    while (Done !== 1'b1 && i < extra) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_done"}, 32'(Done), 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      if (Done === 1'b1) begin
        chk({tag, "_err"}, 32'(Err), 32'(e.err));
        chk({tag, "_rdata"}, ReadData, e.rd);
      end
    end
  endtask

  task automatic drive_start(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
    Start = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wd;
  endtask

  task automatic clear_start();
    Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic run_access(input vec_t v, input string tag, input int ack_delay);
    exp_t e;
    @(negedge clk);
    drive_start(v.rd, v.wr, v.f3, v.addr, v.wd);
    e.err = v.err;
    e.rd  = (v.rd && !v.err) ? v.rres : model_rd;
    model_rd = e.rd;
    sb_q.push_back(e);
    @(negedge clk);
    clear_start();
    chk({tag, "_busy"}, 32'(Busy), 32'd1);
    chk({tag, "_req"}, 32'(MemReq), 32'(v.req));
    if (v.req) begin
      chk({tag, "_addr"}, MemAddr, {v.addr[31:2], 2'b00});
      chk({tag, "_be"}, 32'(MemBE), 32'(v.be));
      chk({tag, "_we"}, 32'(MemWE), 32'(v.wr));
      if (v.wr) chk({tag, "_wdata"}, MemWData, v.mwd);
      repeat (ack_delay) @(negedge clk);
      MemAck = 1'b1; MemRData = v.rdat;
      @(negedge clk);
      MemAck = 1'b0;
    end
    wait_done(tag, 0);
    @(negedge clk);
    chk({tag, "_idle"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, dones, reqs;
    exp_t e;
    //           rd    wr    f3      addr       wd            rdat          req   be     mwd           err   rres
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 1'b1, 4'hF, 32'h0,        1'b0, 32'hFFFFFF80};
    tbl[1]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0,        1'b1, 4'hC, 32'hBEEFBEEF, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 3'b010, 32'h6,   32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 3'b100, 32'h101, 32'h0,        32'h12345678, 1'b1, 4'hF, 32'h0,        1'b0, 32'h00000056};
    tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h2,   32'h0,        32'h80017FFF, 1'b1, 4'hF, 32'h0,        1'b0, 32'hFFFF8001};
    tbl[5]  = '{1'b1, 1'b0, 3'b101, 32'h0,   32'h0,        32'h8001F00D, 1'b1, 4'hF, 32'h0,        1'b0, 32'h0000F00D};
    tbl[6]  = '{1'b1, 1'b0, 3'b010, 32'h40,  32'h0,        32'hDEADBEEF, 1'b1, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[7]  = '{1'b0, 1'b1, 3'b000, 32'h13,  32'h12345678, 32'h0,        1'b1, 4'h8, 32'h78787878, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 3'b000, 32'h10,  32'h000000A5, 32'h0,        1'b1, 4'h1, 32'hA5A5A5A5, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 3'b010, 32'h20,  32'hCAFEF00D, 32'h0,        1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 3'b001, 32'h200, 32'h1234ABCD, 32'h0,        1'b1, 4'h3, 32'hABCDABCD, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 3'b001, 32'h31,  32'h1111,     32'h0,        1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 3'b100, 32'h0,   32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 3'b000, 32'h0,   32'h0,        32'h0000007F, 1'b1, 4'hF, 32'h0,        1'b0, 32'h0000007F};
    tbl[15] = '{1'b1, 1'b0, 3'b000, 32'h2,   32'h0,        32'h00FF0000, 1'b1, 4'hF, 32'h0,        1'b0, 32'hFFFFFFFF};

    reset_n = 1'b0; Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
    ALUResult = '0; WriteData = '0; MemAck = 1'b0; MemRData = '0;
    #1;
    chk("rst_req", 32'(MemReq), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_be", 32'(MemBE), 32'd0);
    chk("rst_addr", MemAddr, 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) run_access(tbl[i], $sformatf("v%0d", i), i % 3);

    // Start with both or neither direction is ignored.
    @(negedge clk); drive_start(1'b1, 1'b1, 3'b010, 32'h0, 32'h0);
    @(negedge clk); clear_start();
    chk("both_busy", 32'(Busy), 32'd0);
    drive_start(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(negedge clk); clear_start();
    chk("none_busy", 32'(Busy), 32'd0);

    // MemAck in IDLE is ignored.
    MemAck = 1'b1;
    @(negedge clk); MemAck = 1'b0;
    chk("stray_ack_done", 32'(Done), 32'd0);
    chk("stray_ack_busy", 32'(Busy), 32'd0);

    // Ack never arrives: timeout after 4 request cycles.
    @(negedge clk); drive_start(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    e.err = 1'b1; e.rd = model_rd; sb_q.push_back(e);
    @(negedge clk); clear_start();
    n = 0;
    while (MemReq === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("to_req_cycles", n, 32'd4);
    wait_done("to", 0);
    @(negedge clk);
    chk("to_idle", 32'(Busy), 32'd0);

    // Reset in the middle of a request.
    @(negedge clk); drive_start(1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
    @(negedge clk); clear_start();
    chk("mid_rst_req_before", 32'(MemReq), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(MemReq), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_rdata", ReadData, 32'd0);
    model_rd = '0;
    @(negedge clk); reset_n = 1'b1;
    run_access('{1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000F00D, 1'b1, 4'hF, 32'h0,
                 1'b0, 32'h0000F00D}, "post_rst", 0);

    // Start pulsed while busy must not launch a second access.
    @(negedge clk); drive_start(1'b1, 1'b0, 3'b010, 32'h44, 32'h0);
    e.err = 1'b0; e.rd = 32'h11112222; sb_q.push_back(e); model_rd = e.rd;
    @(negedge clk); clear_start();
    chk("bs_req", 32'(MemReq), 32'd1);
    drive_start(1'b1, 1'b0, 3'b010, 32'h88, 32'h0);
    @(negedge clk); clear_start();
    chk("bs_addr", MemAddr, 32'h44);
    MemAck = 1'b1; MemRData = 32'h11112222;
    @(negedge clk); MemAck = 1'b0;
    wait_done("bs", 0);
    dones = 0; reqs = 0;
    repeat (6) begin
      @(negedge clk);
      if (Done === 1'b1) dones++;
      if (MemReq === 1'b1) reqs++;
    end
    chk("bs_extra_done", dones, 32'd0);
    chk("bs_extra_req", reqs, 32'd0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
